// File: rtl/risky_pkg.sv
// Shared definitions for the risky bus arbiter: FSM state type and bus constants.
package risky_pkg;

   localparam int RISKY_BUS_NREQ  = 4;
   localparam int RISKY_BUS_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/risky_rr_pick.sv
// Combinational round-robin search: first candidate at or above ptr, wrapping to 0,
// with an exclude mask to skip a requester that was just forced off the bus.
module risky_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         excl,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    found
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0] cand;
   logic [IDW:0]    idx;

   assign cand = req & ~excl;

   // Walk offsets from farthest to nearest so the nearest hit is the last one written.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (IDW + 1)'(i);
         if (idx >= (IDW + 1)'(NREQ)) idx = idx - (IDW + 1)'(NREQ);
         if (cand[idx[IDW-1:0]]) begin
            winner = idx[IDW-1:0];
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/risky_bus_arb.sv
// Round-robin arbiter for a shared tri-state bus with lock and a one-cycle turnaround.
// Define RISKY_BUS_TIMEOUT_EN to bound how long a locked owner may hold the bus.
module risky_bus_arb
   import risky_pkg::*;
#(
   parameter int NREQ    = RISKY_BUS_NREQ,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic                    gnt_valid,
   output logic                    timeout_err
);
   localparam int IDW = $clog2(NREQ);

   arb_state_t     state, state_n;
   logic [IDW-1:0] owner, owner_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [IDW-1:0] win;
   logic           found;
   logic           hold;
   logic           force_rel;
   logic [NREQ-1:0] excl;

   function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] o);
      if (32'(o) == NREQ - 1) return '0;
      return o + 1'b1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] o);
      return {{(NREQ - 1){1'b0}}, 1'b1} << o;
   endfunction

   assign hold = req[owner] & lock[owner];

`ifdef RISKY_BUS_TIMEOUT_EN
   logic [7:0] cnt, cnt_n;

   assign force_rel = (state == BUSY) && hold && (cnt == 8'(TIMEOUT - 2));

   // Only an uninterrupted locked stretch by the same owner keeps counting.
   always_comb begin
      cnt_n = '0;
      if (state == BUSY && hold && !force_rel) cnt_n = cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_n;
   end
`else
   assign force_rel = 1'b0;
`endif

   assign excl = force_rel ? onehot(owner) : '0;

   risky_rr_pick #(.NREQ(NREQ)) u_pick (
      .req    (req),
      .excl   (excl),
      .ptr    (ptr),
      .winner (win),
      .found  (found)
   );

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_n = BUSY;
               owner_n = win;
               ptr_n   = ptr_after(win);
            end
         end
         BUSY: begin
            if (hold && !force_rel) begin
               state_n = BUSY;
            end else if (found && win == owner) begin
               ptr_n = ptr_after(win);
            end else if (found) begin
               state_n = TURN;
               owner_n = win;
               ptr_n   = ptr_after(win);
            end else begin
               state_n = IDLE;
            end
         end
         TURN: state_n = BUSY;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so gnt lines up with state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         gnt         <= '0;
         gnt_id      <= '0;
         gnt_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         ptr         <= ptr_n;
         gnt         <= (state_n == BUSY) ? onehot(owner_n) : '0;
         gnt_id      <= (state_n == BUSY) ? owner_n : '0;
         gnt_valid   <= (state_n == BUSY);
         timeout_err <= force_rel;
      end
   end

endmodule

// File: tb/tb_risky_bus_arb.sv
// Self-checking bench for risky_bus_arb: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_risky_bus_arb;
   localparam int N = 4;
`ifdef RISKY_BUS_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 16;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] lock = '0;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         gnt_valid;
   logic         timeout_err;

   int tests = 0;
   int fails = 0;

   int   m_own, m_pend, m_ptr, m_held;
   logic m_err;

   always #5 clk = ~clk;

   risky_bus_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .lock        (lock),
      .gnt         (gnt),
      .gnt_id      (gnt_id),
      .gnt_valid   (gnt_valid),
      .timeout_err (timeout_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_search(input logic [N-1:0] r, input int from, input int skip);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (from + k) % N;
         if (r[c] && c != skip) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_pend = -1; m_ptr = 0; m_held = 0; m_err = 1'b0;
   endtask

   // m_own is the requester seeing gnt this cycle (-1: none); m_pend is an owner waiting out the turnaround.
   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
      int w;
      bit hold, forced;
      m_err = 1'b0;
      if (m_pend >= 0) begin
         m_own = m_pend; m_pend = -1; m_held = 0;
      end else if (m_own < 0) begin
         w = rr_search(r, m_ptr, -1);
         if (w >= 0) begin m_own = w; m_ptr = (w + 1) % N; m_held = 0; end
      end else begin
         hold = r[m_own] && l[m_own];
         forced = 1'b0;
`ifdef RISKY_BUS_TIMEOUT_EN
         if (hold) begin
            m_held++;
            if (m_held == TO - 1) forced = 1'b1;
         end
`endif
         if (!hold || forced) begin
            w = rr_search(r, m_ptr, forced ? m_own : -1);
            m_err = forced;
            m_held = 0;
            if (w < 0) m_own = -1;
            else if (w == m_own) m_ptr = (w + 1) % N;
            else begin m_pend = w; m_own = -1; m_ptr = (w + 1) % N; end
         end
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l);
      logic [N-1:0] exp_gnt;
      req = r;
      lock = l;
      @(posedge clk);
      model_step(r, l);
      #1;
      exp_gnt = (m_own >= 0) ? N'(1 << m_own) : '0;
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      checkOutput("gnt_valid", 32'(gnt_valid), 32'(m_own >= 0));
      if (m_own >= 0) checkOutput("gnt_id", 32'(gnt_id), 32'(m_own));
      checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
   endtask

   // Asserts reset a few ns into the cycle so the asynchronous clear is observable before any edge.
   task automatic doReset();
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_valid", 32'(gnt_valid), 32'd0);
      checkOutput("rst_id", 32'(gnt_id), 32'd0);
      checkOutput("rst_err", 32'(timeout_err), 32'd0);
      model_reset();
      req = '0;
      lock = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [N-1:0] rr_seq [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("init_gnt", 32'(gnt), 32'd0);
      checkOutput("init_valid", 32'(gnt_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(4'b0101, 4'b0000); checkOutput("two_req_c1", 32'(gnt), 32'h1);
      applyStimulus(4'b0101, 4'b0000); checkOutput("two_req_c2", 32'(gnt), 32'h0);
      applyStimulus(4'b0101, 4'b0000); checkOutput("two_req_c3", 32'(gnt), 32'h4);

      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b1111, 4'b0000);
         checkOutput("rr_order", 32'(gnt), 32'(rr_seq[i]));
      end

      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0100, 4'b0000);
         checkOutput("sole_req", 32'(gnt), 32'h4);
      end

      doReset();
      applyStimulus(4'b0010, 4'b0010); checkOutput("lock_grant", 32'(gnt), 32'h2);
      applyStimulus(4'b0011, 4'b0011); checkOutput("lock_hold1", 32'(gnt), 32'h2);
      applyStimulus(4'b0011, 4'b0010); checkOutput("lock_hold2", 32'(gnt), 32'h2);
      applyStimulus(4'b0011, 4'b0000); checkOutput("unlock_turn", 32'(gnt), 32'h0);
      applyStimulus(4'b0011, 4'b0000); checkOutput("unlock_next", 32'(gnt), 32'h1);

      doReset();
      applyStimulus(4'b0000, 4'b1111); checkOutput("lock_no_req", 32'(gnt), 32'h0);

`ifdef RISKY_BUS_TIMEOUT_EN
      doReset();
      applyStimulus(4'b1001, 4'b0001); checkOutput("to_c1", 32'(gnt), 32'h1);
      applyStimulus(4'b1001, 4'b0001); checkOutput("to_c2", 32'(gnt), 32'h1);
      applyStimulus(4'b1001, 4'b0001); checkOutput("to_c3", 32'(gnt), 32'h1);
      applyStimulus(4'b1001, 4'b0001); checkOutput("to_c4_err", 32'(timeout_err), 32'h1);
      checkOutput("to_c4_gnt", 32'(gnt), 32'h0);
      applyStimulus(4'b1001, 4'b0001); checkOutput("to_c5", 32'(gnt), 32'h8);
`endif

      doReset();
      applyStimulus(4'b0100, 4'b0000); checkOutput("pre_rst", 32'(gnt), 32'h4);
      doReset();
      applyStimulus(4'b0100, 4'b0000); checkOutput("post_rst", 32'(gnt), 32'h4);

      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] r, l;
         r = N'($urandom);
         l = ($urandom_range(0, 3) != 0) ? N'($urandom) : '0;
         if (i % 97 == 50) doReset();
         applyStimulus(r, l);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
